ct_prio_arb_lock: RTL and testbench
===================================

# ct_prio_arb_lock

Parametrised least-recently-granted (LRG) matrix arbiter for CIU request channels; next generation of the single-cycle matrix priority block. Adds:
- Multi-beat grant lock with an accept handshake.
- An urgent priority class.
- Per-requester starvation ageing that promotes long-waiting requesters into the urgent class.

Sits between N requesting agents (snoop/bus request queues) and one shared downstream port.

## Interface
- NUM, 4, number of requesters (2..16)
- AGE_W, 4, width of per-requester wait counter
- AGE_TH, 12, wait cycles after which a requester is treated as urgent (1..2^AGE_W-1)
- clk  in  1  clock
- rst_b  in  1  reset, asynchronous, active-low
- req  in  NUM  request valid per requester; held until its final beat transfers
- urgent  in  NUM  per-requester urgent class qualifier, sampled only where req set
- req_last  in  NUM  per-requester "this beat is the last"
- accept  in  1  downstream accepts current beat
- flush  in  1  synchronous abort: drops lock, clears ages; matrix kept
- gnt  out  NUM  one-hot grant, zero if no candidate
- gnt_vld  out  1  OR of gnt
- locked  out  1  a multi-beat grant is in progress

## Operation
- Matrix state `prio[i][j]` for i≠j: 1 means j beats i. Diagonal is unused and reads 0.
  - Reset: `prio[i][j]=1` for j<i, so index 0 is highest priority.
- Aged vector: `aged[i] = (age[i] >= AGE_TH)`.
- Candidate mask:
  - `hi = req & (urgent | aged)`.
  - `cand = (|hi) ? hi : req`.
- Unlocked grant: `gnt[i] = cand[i] & ~|(cand & prio[i])`. At most one bit is set, guaranteed by matrix antisymmetry.
- Locked grant: `gnt = onehot(lock_id) & req`. The arbiter ignores other requests, urgency and age.
  - If the locked requester drops req, `gnt=0`. The lock stays set; this is a protocol violation, flagged by assertion.
- Transfer: `xfer = gnt_vld & accept`, granted index k.
  - `xfer & req_last[k]`:
    - Matrix update: `prio[k][j]=1` for all j≠k; `prio[i][k]=0` for all i.
    - `locked` clears, `age[k]` clears.
  - `xfer & ~req_last[k]`: `locked` sets and `lock_id=k`. The matrix is not updated until the final beat.
  - No xfer: state holds and `gnt` stays stable while inputs are stable.
- Ageing, per i, each cycle:
  - `age[i]` clears if `~req[i]`.
  - Else it increments, saturating at `2^AGE_W-1`, when req[i] is set and i is not the transferring index.
  - Else it holds.
- flush takes priority over xfer in the same cycle:
  - `locked=0`, all `age=0`.
  - No matrix update, even if a last beat transfers in that cycle.
- Simultaneous aged and urgent requesters share one class; LRG order decides between them.
- Single requester: granted every cycle, and its age never reaches AGE_TH while it is accepted.

## Timing
- Grant is combinational from req/urgent plus registered state: 0-cycle latency, req to gnt in the same cycle.
- State (matrix, ages, lock, lock_id) updates on posedge clk. The new grant order is visible the cycle after the final-beat xfer.
- Reset values:
  - `gnt=0`, `gnt_vld=0`, `locked=0`, `lock_id=0`, all `age=0`.
  - Matrix as above.
- Asynchronous reset mid-burst: the lock is lost immediately and outputs go to reset values in the same cycle rst_b falls.
- No combinational path from accept to gnt.

## Structure
- Shared package `ct_prio_pkg`:
  - Localparam `AGE_MAX = 2^AGE_W-1`.
  - Onehot-to-index function, which is also used for `lock_id`.
- Sub-module `ct_prio_matrix`:
  - Parameter NUM.
  - Inputs: `cand`, `upd_vld`, `upd_onehot`.
  - Output: `sel`.
  - Holds the matrix registers and async reset.
- Top-level holds the lock register, age counters, class select, flush handling and a one-hot gnt assertion.

## Test plan
- NUM=4; req=4'b1111, accept=1, all last: gnt sequence is 0001, 0010, 0100, 1000, 0001.
- req=4'b0011 with req0 doing a 3-beat burst (last on beat 3), accept=1: gnt=0001 for 3 cycles with locked=1 on cycles 2-3, then 0010.
- During a req1 burst, assert urgent[3]: the burst completes, then gnt=1000 ahead of req0/req2.
- AGE_TH=12; req=4'b0011, req1 never urgent, urgent[0] held with continuous single-beat grants to 0: req1 is granted on the 13th cycle after raising req.
- Mid-burst, flush=1 together with accept and last: locked=0, ages=0, and the next-cycle order is unchanged from before the burst.
- Assert rst_b low mid-burst: gnt=0 and locked=0 immediately; after release, req=4'b1010 gives gnt=0010.

Source files
------------

// File: rtl/ct_prio_pkg.sv
// Shared types, limits and helpers for the ct_prio LRG arbiter family.
package ct_prio_pkg;

  localparam int unsigned MAX_NUM   = 16;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned AGE_W_DEF = 4;
  localparam int unsigned AGE_MAX   = (1 << AGE_W_DEF) - 1;

  typedef enum logic {
    LK_IDLE,
    LK_BURST
  } lock_st_e;

  // OR of set-bit positions; exact for one-hot or zero inputs
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_NUM-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_NUM; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ct_prio_matrix.sv
// Least-recently-granted priority matrix: row i bit j set means j beats i.
module ct_prio_matrix #(
  parameter int unsigned NUM = 4
) (
  input  logic           clk,
  input  logic           rst_b,
  input  logic [NUM-1:0] cand,
  input  logic           upd_vld,
  input  logic [NUM-1:0] upd_onehot,
  output logic [NUM-1:0] sel
);

  logic [NUM-1:0] prio [NUM];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int unsigned i = 0; i < NUM; i++) begin
        for (int unsigned j = 0; j < NUM; j++) begin
          prio[i][j] <= (j < i);
        end
      end
    end else if (upd_vld) begin
      // winner's row: everyone beats it; winner's column: it beats nobody
      for (int unsigned i = 0; i < NUM; i++) begin
        if (upd_onehot[i]) prio[i] <= ~upd_onehot;
        else               prio[i] <= prio[i] & ~upd_onehot;
      end
    end
  end

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM; i++) begin
      sel[i] = cand[i] & ~|(cand & prio[i]);
    end
  end

endmodule

// File: rtl/ct_prio_arb_lock.sv
// LRG matrix arbiter with multi-beat grant lock, urgent class and starvation ageing.
module ct_prio_arb_lock
  import ct_prio_pkg::*;
#(
  parameter int unsigned NUM    = 4,
  parameter int unsigned AGE_W  = AGE_W_DEF,
  parameter int unsigned AGE_TH = 12
) (
  input  logic           clk,
  input  logic           rst_b,
  input  logic [NUM-1:0] req,
  input  logic [NUM-1:0] urgent,
  input  logic [NUM-1:0] req_last,
  input  logic           accept,
  input  logic           flush,
  output logic [NUM-1:0] gnt,
  output logic           gnt_vld,
  output logic           locked
);

  localparam logic [AGE_W-1:0] AGE_SAT = '1;

  lock_st_e         lock_st;
  logic [IDX_W-1:0] lock_id;
  logic [AGE_W-1:0] age [NUM];

  logic [NUM-1:0]     aged, hi, cand, sel, lock_oh, gnt_int;
  logic [MAX_NUM-1:0] gnt_ext;
  logic               xfer, last_beat, upd_vld;

  always_comb begin
    aged    = '0;
    lock_oh = '0;
    for (int unsigned i = 0; i < NUM; i++) begin
      aged[i]    = (32'(age[i]) >= AGE_TH);
      lock_oh[i] = (lock_id == IDX_W'(i));
    end
  end

  assign hi   = req & (urgent | aged);
  assign cand = (|hi) ? hi : req;

  ct_prio_matrix #(.NUM(NUM)) u_matrix (
    .clk        (clk),
    .rst_b      (rst_b),
    .cand       (cand),
    .upd_vld    (upd_vld),
    .upd_onehot (gnt),
    .sel        (sel)
  );

  // Gate on rst_b so the grant drops in the same cycle reset asserts
  assign gnt_int   = (lock_st == LK_BURST) ? (lock_oh & req) : sel;
  assign gnt       = rst_b ? gnt_int : '0;
  assign gnt_vld   = |gnt;
  assign locked    = (lock_st == LK_BURST);
  assign xfer      = gnt_vld & accept;
  assign last_beat = |(gnt & req_last);
  assign upd_vld   = xfer & last_beat & ~flush;

  always_comb begin
    gnt_ext          = '0;
    gnt_ext[NUM-1:0] = gnt;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      lock_st <= LK_IDLE;
      lock_id <= '0;
    end else if (flush) begin
      lock_st <= LK_IDLE;
    end else if (xfer) begin
      if (last_beat) begin
        lock_st <= LK_IDLE;
      end else begin
        lock_st <= LK_BURST;
        lock_id <= onehot_to_idx(gnt_ext);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int unsigned i = 0; i < NUM; i++) age[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM; i++) begin
        if (flush || !req[i]) begin
          age[i] <= '0;
        end else if (xfer && gnt[i]) begin
          if (last_beat) age[i] <= '0;
        end else if (age[i] != AGE_SAT) begin
          age[i] <= age[i] + 1'b1;
        end
      end
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_b) $onehot0(gnt));
  a_lock_req_held: assert property (@(posedge clk) disable iff (!rst_b) locked |-> |(lock_oh & req));

endmodule

// File: tb/tb_ct_prio_arb_lock.sv
// Directed and randomized bench for ct_prio_arb_lock against an ordered-list LRG model.
module tb_ct_prio_arb_lock;

  localparam int unsigned NUM    = 4;
  localparam int unsigned AGE_W  = 4;
  localparam int unsigned AGE_TH = 12;
  localparam int          AGE_TOP = (1 << AGE_W) - 1;

  logic           clk = 1'b0;
  logic           rst_b;
  logic [NUM-1:0] req, urgent, req_last;
  logic           accept, flush;
  logic [NUM-1:0] gnt;
  logic           gnt_vld, locked;

  int checks = 0;
  int errors = 0;

  int order[$];
  int m_age [NUM];
  bit m_lock;
  int m_own;
  int m_done;

  ct_prio_arb_lock #(.NUM(NUM), .AGE_W(AGE_W), .AGE_TH(AGE_TH)) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .req      (req),
    .urgent   (urgent),
    .req_last (req_last),
    .accept   (accept),
    .flush    (flush),
    .gnt      (gnt),
    .gnt_vld  (gnt_vld),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    order  = {0, 1, 2, 3};
    for (int i = 0; i < NUM; i++) m_age[i] = 0;
    m_lock = 1'b0;
    m_own  = 0;
  endfunction

  function automatic bit is_hi(int i);
    return req[i] && (urgent[i] || m_age[i] >= AGE_TH);
  endfunction

  function automatic logic [NUM-1:0] model_gnt();
    bit any_hi = 1'b0;
    if (m_lock) return req[m_own] ? NUM'(1 << m_own) : '0;
    for (int i = 0; i < NUM; i++) if (is_hi(i)) any_hi = 1'b1;
    foreach (order[p]) begin
      if (req[order[p]] && (!any_hi || is_hi(order[p]))) return NUM'(1 << order[p]);
    end
    return '0;
  endfunction

  function automatic void model_step(input logic [NUM-1:0] eg);
    int  k = -1;
    bit  xf, lst;
    int  pos = 0;
    for (int i = 0; i < NUM; i++) if (eg[i]) k = i;
    xf  = (k >= 0) && accept;
    lst = xf && req_last[k];
    m_done = lst ? k : -1;
    if (flush) begin
      m_lock = 1'b0;
      for (int i = 0; i < NUM; i++) m_age[i] = 0;
      return;
    end
    if (xf) begin
      if (lst) begin
        foreach (order[p]) if (order[p] == k) pos = p;
        order.delete(pos);
        order.push_back(k);
        m_lock = 1'b0;
      end else begin
        m_lock = 1'b1;
        m_own  = k;
      end
    end
    for (int i = 0; i < NUM; i++) begin
      if (!req[i])               m_age[i] = 0;
      else if (xf && i == k)     m_age[i] = lst ? 0 : m_age[i];
      else if (m_age[i] < AGE_TOP) m_age[i] = m_age[i] + 1;
    end
  endfunction

  task automatic cyc(input string tag, input int xg = -1, input int xl = -1);
    logic [NUM-1:0] eg;
    eg = model_gnt();
    #1;
    chk({tag, "_gnt"},  32'(gnt),     32'(eg));
    chk({tag, "_vld"},  32'(gnt_vld), 32'(|eg));
    chk({tag, "_lock"}, 32'(locked),  32'(m_lock));
    if (xg >= 0) chk({tag, "_dgnt"},  32'(gnt),    xg);
    if (xl >= 0) chk({tag, "_dlock"}, 32'(locked), xl);
    @(posedge clk);
    model_step(eg);
    #1;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    req = '1; urgent = '0; req_last = '1; accept = 1'b1; flush = 1'b0;
    #1;
    chk("rst_gnt",    32'(gnt),     0);
    chk("rst_lock",   32'(locked),  0);
    chk("rst_vld",    32'(gnt_vld), 0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    req   = '0;
    model_reset();
  endtask

  logic [NUM-1:0] pend;

  initial begin
    model_reset();
    do_reset();

    // Round-robin with all single-beat requests
    req = 4'b1111; req_last = 4'b1111; accept = 1'b1;
    cyc("rr0", 1); cyc("rr1", 2); cyc("rr2", 4); cyc("rr3", 8); cyc("rr4", 1);

    // Three-beat burst on requester 0
    do_reset();
    req = 4'b0011; accept = 1'b1;
    req_last = 4'b1110; cyc("bst1", 1, 0);
    req_last = 4'b1110; cyc("bst2", 1, 1);
    req_last = 4'b1111; cyc("bst3", 1, 1);
    req = 4'b0010;      cyc("bst4", 2, 0);

    // Urgent request waits for an in-flight burst
    do_reset();
    accept = 1'b1;
    req = 4'b0010; req_last = 4'b1101; cyc("urg0", 2, 0);
    req = 4'b1111; urgent = 4'b1000;   cyc("urg1", 2, 1);
    req_last = 4'b1111;                cyc("urg2", 2, 1);
    req = 4'b1101;                     cyc("urg3", 8, 0);
    urgent = '0;

    // Ageing promotes a starved requester on its 13th waiting cycle
    do_reset();
    req = 4'b0011; urgent = 4'b0001; req_last = 4'b1111; accept = 1'b1;
    for (int c = 0; c < 13; c++) cyc("age", (c < 12) ? 1 : 2);
    urgent = '0;

    // Flush during a final beat: lock drops, order unchanged
    do_reset();
    accept = 1'b1; req_last = 4'b1111;
    req = 4'b0100;      cyc("fl0", 4, 0);
    req = 4'b0011; req_last = 4'b1110; cyc("fl1", 1, 0);
    flush = 1'b1;  req_last = 4'b1111; cyc("fl2", 1, 1);
    flush = 1'b0;                      cyc("fl3", 1, 0);

    // Asynchronous reset mid-burst
    do_reset();
    req = 4'b1111; req_last = 4'b0000; accept = 1'b1;
    cyc("ar0", 1, 0);
    cyc("ar1", 1, 1);
    rst_b = 1'b0;
    #1;
    chk("ar_gnt",  32'(gnt),    0);
    chk("ar_lock", 32'(locked), 0);
    model_reset();
    req = '0;
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    req = 4'b1010; req_last = 4'b1111;
    cyc("ar2", 2, 0);

    // Randomized traffic honouring the hold-until-last protocol
    do_reset();
    pend = '0;
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < NUM; i++) begin
        req[i]    = pend[i] | ($urandom_range(0, 1) == 1);
        urgent[i] = ($urandom_range(0, 7) == 0);
      end
      req_last = NUM'($urandom);
      accept   = ($urandom_range(0, 9) < 7);
      flush    = ($urandom_range(0, 39) == 0);
      cyc("rnd");
      pend = req;
      if (m_done >= 0) pend[m_done] = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
